// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: channel widths, A/D opcodes and the responder FSM state type.
// Used by the memory responder and by the instruction-cache master.
package tl_pkg;

    localparam int TL_AW   = 64;
    localparam int TL_DW   = 64;
    localparam int TL_SZW  = 4;
    localparam int TL_SRCW = 8;

    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_ACK         = 3'd0;
    localparam logic [2:0] TL_ACK_DATA    = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } tl_state_e;

    // Number of D beats minus one for a Get of 2^size bytes on a 64-bit bus.
    function automatic logic [12:0] tl_get_beats_m1(input logic [TL_SZW-1:0] size);
        if (size <= 4'd3) begin
            return 13'd0;
        end
        return (13'd1 << (size - 4'd3)) - 13'd1;
    endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL A and D channels between one master and one slave.
interface tilelink;

    logic                         a_valid;
    logic                         a_ready;
    logic [2:0]                   a_opcode;
    logic [tl_pkg::TL_SZW-1:0]    a_size;
    logic [tl_pkg::TL_SRCW-1:0]   a_source;
    logic [tl_pkg::TL_AW-1:0]     a_address;
    logic [tl_pkg::TL_DW/8-1:0]   a_mask;
    logic [tl_pkg::TL_DW-1:0]     a_data;

    logic                         d_valid;
    logic                         d_ready;
    logic [2:0]                   d_opcode;
    logic [tl_pkg::TL_SZW-1:0]    d_size;
    logic [tl_pkg::TL_SRCW-1:0]   d_source;
    logic                         d_denied;
    logic [tl_pkg::TL_DW-1:0]     d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );

endinterface

// File: rtl/mem_sram.sv
// DEPTH x 64 synchronous SRAM, one byte-wide array per lane so byte enables map onto block RAM.
// Read data is registered and holds its value on cycles without a read enable.
module mem_sram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    input  logic [7:0]    wbe,
    output logic [63:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clk) begin
                if (we && wbe[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
                if (re) begin
                    lane_rdata_reg <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL responder backing a 64-bit SRAM: Get bursts and single-beat Puts, one transaction in flight.
// Define TL_MEM_DELAY_EN to insert WAIT_CYC stall cycles between accept and the first D beat.
module tl_mem_responder
    import tl_pkg::*;
#(
    parameter int          DEPTH    = 4096,
    parameter logic [63:0] BASE     = 64'h8000_0000,
    parameter int          MAX_SIZE = 6,
    parameter int          WAIT_CYC = 3
) (
    input  logic   clk,
    input  logic   rst,
    tilelink.slave bus
);

    localparam int               AW     = $clog2(DEPTH);
    localparam logic [63:0]      LIMIT  = 64'(DEPTH) << 3;
    localparam logic [TL_SZW-1:0] MAX_SZ = TL_SZW'(MAX_SIZE);

    tl_state_e          state_reg, state_next;
    logic               get_reg;
    logic               denied_reg;
    logic [2:0]         d_op_reg;
    logic [TL_SZW-1:0]  size_reg;
    logic [TL_SRCW-1:0] source_reg;
    logic [AW-1:0]      idx_reg;
    logic [12:0]        beats_left_reg;

    logic [63:0] offset;
    logic [63:0] align_mask;
    logic        is_get, is_put, req_denied;
    logic        a_ready_int, d_valid_int;
    logic        accept, d_fire, last_beat, wait_done;
    logic        sram_re, sram_we;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_rdata;

    // Request decode; unsigned offset makes addresses below BASE fail the range test as well.
    assign offset     = bus.a_address - BASE;
    assign align_mask = (64'd1 << bus.a_size) - 64'd1;
    assign is_get     = (bus.a_opcode == TL_GET);
    assign is_put     = (bus.a_opcode == TL_PUT_FULL) || (bus.a_opcode == TL_PUT_PARTIAL);
    assign req_denied = (bus.a_address < BASE) || (offset >= LIMIT)
                     || ((bus.a_address & align_mask) != 64'd0)
                     || (bus.a_size > MAX_SZ)
                     || (is_put && (bus.a_size > 4'd3))
                     || !(is_get || is_put);

    assign a_ready_int = (state_reg == ST_IDLE) && !rst;
    assign d_valid_int = (state_reg == ST_RESP);
    assign accept      = bus.a_valid && a_ready_int;
    assign d_fire      = d_valid_int && bus.d_ready;
    assign last_beat   = (beats_left_reg == 13'd0);

`ifdef TL_MEM_DELAY_EN
    localparam int WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    logic [WCW-1:0] wait_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (accept) begin
            wait_cnt_reg <= WCW'(WAIT_CYC - 1);
        end else if ((state_reg == ST_WAIT) && (wait_cnt_reg != '0)) begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
        end
    end

    assign wait_done = (wait_cnt_reg == '0);
`else
    assign wait_done = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
`ifdef TL_MEM_DELAY_EN
                    state_next = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
`else
                    state_next = ST_RESP;
`endif
                end
            end
            ST_WAIT: if (wait_done) state_next = ST_RESP;
            ST_RESP: if (d_fire && last_beat) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            get_reg        <= 1'b0;
            denied_reg     <= 1'b0;
            d_op_reg       <= TL_ACK;
            size_reg       <= '0;
            source_reg     <= '0;
            idx_reg        <= '0;
            beats_left_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                get_reg        <= is_get;
                denied_reg     <= req_denied;
                d_op_reg       <= is_get ? TL_ACK_DATA : TL_ACK;
                size_reg       <= bus.a_size;
                source_reg     <= bus.a_source;
                idx_reg        <= offset[AW+2:3];
                beats_left_reg <= is_get ? tl_get_beats_m1(bus.a_size) : 13'd0;
            end else if (d_fire && !last_beat) begin
                idx_reg        <= idx_reg + 1'b1;
                beats_left_reg <= beats_left_reg - 13'd1;
            end
        end
    end

    // The next word is fetched on the handshake edge so back-to-back beats need no bubble.
    assign sram_re   = (accept && is_get && !req_denied)
                    || (d_fire && !last_beat && get_reg && !denied_reg);
    assign sram_we   = accept && is_put && !req_denied;
    assign sram_addr = accept ? offset[AW+2:3] : idx_reg + 1'b1;

    mem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .re    (sram_re),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (bus.a_data),
        .wbe   (bus.a_mask),
        .rdata (sram_rdata)
    );

    assign bus.a_ready  = a_ready_int;
    assign bus.d_valid  = d_valid_int;
    assign bus.d_opcode = d_op_reg;
    assign bus.d_size   = size_reg;
    assign bus.d_source = source_reg;
    assign bus.d_denied = d_valid_int && denied_reg;
    assign bus.d_data   = (d_valid_int && get_reg && !denied_reg) ? sram_rdata : 64'd0;

endmodule
